sort_job_arbiter: RTL
=====================

Name: sort_job_arbiter

Overview:
- Controller and two-requester arbiter in front of the team's 16-bit insertion sorter.
- Accepts a job, i.e. a valid/ready word stream terminated by last, from requester 0 or 1.
- Drives the sorter's toggle-style clear/push/sort/pop commands, waits for each to complete, then streams the sorted words back on a single response port tagged with the requester id.
- One job is in flight at a time; the grant is held from the first word until the last result word is taken.

Parameters:
- DW, 16: data width; must match the sorter.
- MAXLEN, 254: maximum words per job; must be at most sorter depth minus 1.
- CW, 8: width of the internal word and pop counters.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- enable  in  1  clock enable; when low, all state, counters and outputs hold
- r0_valid  in  1  requester 0 word valid
- r0_ready  out  1  requester 0 word accepted
- r0_data  in  DW  requester 0 word
- r0_last  in  1  requester 0 final word of job
- r1_valid, r1_ready, r1_data, r1_last: same as r0_* for requester 1
- rsp_valid  out  1  result word valid
- rsp_ready  in  1  result consumer ready
- rsp_data  out  DW  result word
- rsp_last  out  1  final result word of job
- rsp_id  out  1  requester that owns the job
- s_clear, s_push, s_sort, s_pop  out  1 each  sorter command lines; each command is one toggle of the line
- s_din  out  DW  push data to sorter
- s_dout  in  DW  pop data from sorter
- s_idle  in  1  sorter idle
- busy  out  1  high whenever the state is not IDLE
- err_overflow  out  1  sticky; set when a job exceeds MAXLEN; cleared only by reset

Behaviour:
- Reset: all outputs 0, state IDLE, last_grant=1 so requester 0 wins first, counters 0, command lines 0.
- Command handshake: toggle the line, enter WAIT_LO until s_idle==0, then WAIT_HI until s_idle==1, then return to the calling state.
  - s_din must be stable from the toggle cycle through the end of WAIT_HI.
  - A command is never issued while s_idle==0.
- IDLE:
  - If any rN_valid, grant by round-robin: the requester other than last_grant wins a tie.
  - Latch grant into rsp_id and last_grant, then go to CLR.
- CLR: issue clear, then go to LOAD.
- LOAD: rN_ready=1 for one cycle, only for the granted requester; the word is taken when valid&ready.
  - If count<MAXLEN: drive s_din=data, count++, issue push, then return to LOAD.
  - If count==MAXLEN: the word is accepted and discarded, and err_overflow is set.
  - A word accepted with last set ends the load phase, then go to SORT.
  - The non-granted requester's ready stays 0 throughout the job.
- SORT:
  - If count>=2, issue sort.
  - If count==1, skip the sort.
  - Then go to UNLOAD with pcnt=count.
- UNLOAD:
  - Issue pop; after WAIT_HI, register s_dout into rsp_data and assert rsp_valid.
  - rsp_last=1 when pcnt==1.
  - Hold rsp_data/rsp_last stable until rsp_ready; then pcnt-- and deassert rsp_valid.
  - If pcnt reaches 0, go to IDLE; otherwise pop again.
  - Result order is sorter pop order: largest first, descending.
- Minimum latency per command: 3 cycles after the toggle, given the sorter's 2-stage edge detect plus 1 state cycle.
- Simultaneous r0/r1 valid in IDLE is resolved by round-robin only.
- Valid words arriving during another job wait; they are never dropped.
- enable low mid-handshake: freeze; commands resume with no extra toggle.
- Async reset mid-job: return to IDLE immediately. The job is lost and the sorter is reset by the shared rstn.

Test Plan:
- r0 sends 3,1,2 (last on 2) -> clear, 3 pushes, 1 sort, 3 pops; rsp_data 3,2,1 with rsp_id=0 and rsp_last only on 1; r1_ready stays 0.
- r0 and r1 both valid at the first IDLE -> r0 job completes first, then r1; two further back-to-back r0,r1 contests alternate grants.
- Single-word job r1 sends 0x00FF last -> no s_sort toggle; one rsp word 0x00FF with rsp_last=1, rsp_id=1.
- MAXLEN+2 words from r0 -> all accepted, exactly MAXLEN pushes, err_overflow=1, exactly MAXLEN response words.
- rsp_ready held low for 10 cycles mid-unload -> rsp_data/rsp_last stable and no extra s_pop toggle; resumes correctly afterwards.
- rstn pulsed during LOAD; separately, enable low for 5 cycles during WAIT_LO -> after reset all outputs 0, state IDLE, next job correct; the enable-low case completes with an identical result sequence.

Source files
------------

// File: rtl/sort_job_arbiter_if.sv
// Bundle of the requester, response and sorter-command signals around the
// sort job arbiter. "slave" is the arbiter's view; "master" is the view of
// the surrounding logic (requesters, result consumer and sorter).
interface sort_job_arbiter_if #(
  parameter int DW = 16
);
  logic          r0_valid;
  logic          r0_ready;
  logic [DW-1:0] r0_data;
  logic          r0_last;
  logic          r1_valid;
  logic          r1_ready;
  logic [DW-1:0] r1_data;
  logic          r1_last;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_last;
  logic          rsp_id;
  logic          s_clear;
  logic          s_push;
  logic          s_sort;
  logic          s_pop;
  logic [DW-1:0] s_din;
  logic [DW-1:0] s_dout;
  logic          s_idle;

  modport slave (
    input  r0_valid, r0_data, r0_last, r1_valid, r1_data, r1_last,
           rsp_ready, s_dout, s_idle,
    output r0_ready, r1_ready, rsp_valid, rsp_data, rsp_last, rsp_id,
           s_clear, s_push, s_sort, s_pop, s_din
  );

  modport master (
    output r0_valid, r0_data, r0_last, r1_valid, r1_data, r1_last,
           rsp_ready, s_dout, s_idle,
    input  r0_ready, r1_ready, rsp_valid, rsp_data, rsp_last, rsp_id,
           s_clear, s_push, s_sort, s_pop, s_din
  );
endinterface

// File: rtl/sort_job_arbiter.sv
// Two-requester job arbiter and command sequencer for the 16-bit insertion
// sorter. A job is loaded word by word, sorted, then popped back out largest
// first on the response port, tagged with the owning requester.
module sort_job_arbiter #(
  parameter int DW     = 16,
  parameter int MAXLEN = 254,
  parameter int CW     = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                enable,
  sort_job_arbiter_if.slave   bus,
  output logic                busy,
  output logic                err_overflow
);

  typedef enum logic [2:0] {
    IDLE, CLR, LOAD, SORT, UNLOAD, RESP, WAIT_LO, WAIT_HI
  } state_t;

  localparam logic [CW-1:0] MAX_CNT = CW'(MAXLEN);

  state_t        state;
  state_t        ret_state;   // state to resume once a sorter command completes
  logic          last_grant;
  logic [CW-1:0] count;       // words pushed into the sorter for this job
  logic [CW-1:0] pcnt;        // result words still to be returned
  logic          next_grant;
  logic          sel_valid;
  logic          sel_last;
  logic          sel_ready;
  logic [DW-1:0] sel_data;

  // Round-robin: on a tie the requester that did not win last time gets it.
  assign next_grant = (bus.r0_valid && bus.r1_valid) ? ~last_grant : bus.r1_valid;
  assign busy       = (state != IDLE);

  // Route the granted requester's word channel to the load logic.
  // NOTE: every output gets a default before the if, so no latch is inferred.
  always_comb begin
    sel_valid = bus.r0_valid;
    sel_last  = bus.r0_last;
    sel_data  = bus.r0_data;
    sel_ready = bus.r0_ready;
    if (bus.rsp_id) begin
      sel_valid = bus.r1_valid;
      sel_last  = bus.r1_last;
      sel_data  = bus.r1_data;
      sel_ready = bus.r1_ready;
    end
  end

  // Job sequencer: grant, clear, load, sort, unload, each sorter command
  // being a line toggle followed by a wait for s_idle to fall and rise again.
  // NOTE: non-blocking assignments throughout, so every branch sees the
  // pre-edge values of state and outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      ret_state     <= IDLE;
      last_grant    <= 1'b1;
      count         <= '0;
      pcnt          <= '0;
      err_overflow  <= 1'b0;
      bus.r0_ready  <= 1'b0;
      bus.r1_ready  <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_last  <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.s_clear   <= 1'b0;
      bus.s_push    <= 1'b0;
      bus.s_sort    <= 1'b0;
      bus.s_pop     <= 1'b0;
      bus.s_din     <= '0;
    end else if (enable) begin
      case (state)
        IDLE: begin
          if (bus.r0_valid || bus.r1_valid) begin
            bus.rsp_id <= next_grant;
            last_grant <= next_grant;
            count      <= '0;
            state      <= CLR;
          end
        end
        CLR: begin
          if (bus.s_idle) begin
            bus.s_clear <= ~bus.s_clear;
            ret_state   <= LOAD;
            state       <= WAIT_LO;
          end
        end
        LOAD: begin
          if (!sel_ready) begin
            // Offer one word slot, only while the sorter can take a push.
            bus.r0_ready <= bus.s_idle && !bus.rsp_id;
            bus.r1_ready <= bus.s_idle && bus.rsp_id;
          end else if (sel_valid) begin
            bus.r0_ready <= 1'b0;
            bus.r1_ready <= 1'b0;
            if (count != MAX_CNT) begin
              bus.s_din  <= sel_data;
              bus.s_push <= ~bus.s_push;
              count      <= count + CW'(1);
              ret_state  <= sel_last ? SORT : LOAD;
              state      <= WAIT_LO;
            end else begin
              // Job longer than the sorter allows: swallow the word.
              err_overflow <= 1'b1;
              if (sel_last) state <= SORT;
            end
          end
        end
        SORT: begin
          if (bus.s_idle) begin
            pcnt <= count;
            if (count >= CW'(2)) begin
              bus.s_sort <= ~bus.s_sort;
              ret_state  <= UNLOAD;
              state      <= WAIT_LO;
            end else begin
              state <= UNLOAD;
            end
          end
        end
        UNLOAD: begin
          if (bus.s_idle) begin
            bus.s_pop <= ~bus.s_pop;
            ret_state <= RESP;
            state     <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (!bus.s_idle) state <= WAIT_HI;
        end
        WAIT_HI: begin
          if (bus.s_idle) begin
            state <= ret_state;
            if (ret_state == RESP) begin
              bus.rsp_data  <= bus.s_dout;
              bus.rsp_valid <= 1'b1;
              bus.rsp_last  <= (pcnt == CW'(1));
            end
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_last  <= 1'b0;
            pcnt          <= pcnt - CW'(1);
            state         <= (pcnt == CW'(1)) ? IDLE : UNLOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
